// File: rtl/mux_tree_pkg.sv
// rtl/mux_tree_pkg.sv - shared sizing helpers for the pipelined mux tree
package mux_tree_pkg;

    localparam int MAX_LEVELS = 4;

    function automatic int num_in(input int levels);
        return 1 << (2 * levels);
    endfunction

    function automatic int sel_w(input int levels);
        return 2 * levels;
    endfunction

    // Offset (in nodes) of tree level `level` in the flattened node vector; level 0 is in_data.
    function automatic int node_base(input int levels, input int level);
        int b;
        b = 0;
        for (int j = 0; j < level; j++) begin
            b += 1 << (2 * (levels - j));
        end
        return b;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// rtl/mux_tree_pipe_if.sv - sample-in / sample-out bundle of the pipelined mux tree
interface mux_tree_pipe_if #(
    parameter int DATA_W = 8,
    parameter int LEVELS = 2
);
    import mux_tree_pkg::*;

    localparam int NUM_IN = num_in(LEVELS);
    localparam int SEL_W  = sel_w(LEVELS);

    logic [NUM_IN*DATA_W-1:0] in_data;
    logic                     in_valid;
    logic [SEL_W-1:0]         sel;
    logic                     scan_en;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic [SEL_W-1:0]         out_sel;

    modport master (
        output in_data, in_valid, sel, scan_en,
        input  out_data, out_valid, out_sel
    );

    modport slave (
        input  in_data, in_valid, sel, scan_en,
        output out_data, out_valid, out_sel
    );

endinterface

// File: rtl/mux4_stage.sv
// rtl/mux4_stage.sv - one registered 4:1 node of the mux tree
module mux4_stage #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [1:0]            sel,
    input  logic [4*DATA_W-1:0]   din,
    output logic [DATA_W-1:0]     dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (load) begin
            dout <= din[sel*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined NUM_IN:1 mux tree with valid pipeline and auto-scan
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEVELS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_tree_pipe_if.slave   bus
);

    localparam int NUM_IN   = num_in(LEVELS);
    localparam int SEL_W    = sel_w(LEVELS);
    localparam int OUT_NODE = node_base(LEVELS, LEVELS);

    // Every tree node (inputs included) lives in one flat vector, level by level.
    logic [(OUT_NODE+1)*DATA_W-1:0] tree;
    logic [SEL_W-1:0]               scan_idx;
    logic [SEL_W-1:0]               eff_sel;
    logic [SEL_W-1:0]               sel_q [1:LEVELS];
    logic [LEVELS:1]                v_q;

    assign eff_sel                  = bus.scan_en ? scan_idx : bus.sel;
    assign tree[NUM_IN*DATA_W-1:0]  = bus.in_data;

    // NUM_IN is a power of two, so the natural SEL_W-bit wrap gives NUM_IN-1 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx <= '0;
        end else if (!bus.scan_en) begin
            scan_idx <= '0;
        end else if (bus.in_valid) begin
            scan_idx <= scan_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 1; k <= LEVELS; k++) begin
                sel_q[k] <= '0;
            end
        end else begin
            v_q[1] <= bus.in_valid;
            if (bus.in_valid) begin
                sel_q[1] <= eff_sel;
            end
            for (int k = 2; k <= LEVELS; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) begin
                    sel_q[k] <= sel_q[k-1];
                end
            end
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int NODES   = 1 << (2 * (LEVELS - k));
        localparam int IN_BASE = node_base(LEVELS, k - 1);
        localparam int OUT_BASE = node_base(LEVELS, k);

        logic [1:0] lsel;
        logic       lload;

        // Level k steers with its own select digit, travelling alongside the data.
        if (k == 1) begin : g_first
            assign lsel  = eff_sel[1:0];
            assign lload = bus.in_valid;
        end else begin : g_rest
            assign lsel  = sel_q[k-1][2*k-1:2*k-2];
            assign lload = v_q[k-1];
        end

        for (genvar n = 0; n < NODES; n++) begin : g_node
            mux4_stage #(
                .DATA_W (DATA_W)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (lload),
                .sel   (lsel),
                .din   (tree[(IN_BASE + 4*n)*DATA_W +: 4*DATA_W]),
                .dout  (tree[(OUT_BASE + n)*DATA_W +: DATA_W])
            );
        end
    end

    assign bus.out_data  = tree[OUT_NODE*DATA_W +: DATA_W];
    assign bus.out_sel   = sel_q[LEVELS];
    assign bus.out_valid = v_q[LEVELS];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - self-checking bench for mux_tree_pipe
module tb_mux_tree_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_tree_pipe_if #(.DATA_W(8),  .LEVELS(2)) bus2 ();
    mux_tree_pipe_if #(.DATA_W(8),  .LEVELS(1)) bus1 ();
    mux_tree_pipe_if #(.DATA_W(16), .LEVELS(3)) bus3 ();

    mux_tree_pipe #(.DATA_W(8),  .LEVELS(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus2));
    mux_tree_pipe #(.DATA_W(8),  .LEVELS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux_tree_pipe #(.DATA_W(16), .LEVELS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int total = 0;
    int bad   = 0;

    // Reference model for the LEVELS=2 instance: a queue of samples in flight.
    bit         q_v [$];
    logic [7:0] q_d [$];
    logic [3:0] q_s [$];
    bit         m_valid;
    logic [7:0] m_data;
    logic [3:0] m_sel;
    int         m_scan;

    function automatic logic [127:0] pat();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'hA0 + i[7:0];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        q_v.delete(); q_d.delete(); q_s.delete();
        q_v.push_back(1'b0); q_d.push_back(8'h00); q_s.push_back(4'h0);
        m_valid = 1'b0; m_data = 8'h00; m_sel = 4'h0; m_scan = 0;
    endtask

    task automatic step2(input bit v, input logic [3:0] s, input bit se, input logic [127:0] data);
        int ch;
        bit tv; logic [7:0] td; logic [3:0] ts;
        bus2.in_valid = v; bus2.sel = s; bus2.scan_en = se; bus2.in_data = data;
        ch = se ? m_scan : int'(s);
        q_v.push_back(v); q_d.push_back(data[ch*8 +: 8]); q_s.push_back(ch[3:0]);
        if (!se) m_scan = 0;
        else if (v) m_scan = (m_scan + 1) % 16;
        @(posedge clk); #1;
        tv = q_v.pop_front(); td = q_d.pop_front(); ts = q_s.pop_front();
        m_valid = tv;
        if (tv) begin m_data = td; m_sel = ts; end
    endtask

    task automatic test_reset();
        bus2.in_valid = 0; bus2.sel = 0; bus2.scan_en = 0; bus2.in_data = '0;
        bus1.in_valid = 0; bus1.sel = 0; bus1.scan_en = 0; bus1.in_data = '0;
        bus3.in_valid = 0; bus3.sel = 0; bus3.scan_en = 0; bus3.in_data = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({bus2.out_valid, bus2.out_sel, bus2.out_data, bus1.out_valid, bus3.out_valid} !== '0) begin
                bad++;
                $display("FAIL reset_hold got v=%0b s=%0d d=%h v1=%0b v3=%0b exp all 0",
                         bus2.out_valid, bus2.out_sel, bus2.out_data, bus1.out_valid, bus3.out_valid);
            end
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step2(1'b0, 4'($urandom_range(0, 15)), 1'b0, pat());
            total++;
            if ({bus2.out_valid, bus2.out_sel, bus2.out_data} !== 13'h0) begin
                bad++;
                $display("FAIL reset_idle got v=%0b s=%0d d=%h exp 0/0/00",
                         bus2.out_valid, bus2.out_sel, bus2.out_data);
            end
        end
    endtask

    task automatic test_manual();
        logic [3:0] sels [4] = '{4'd5, 4'd12, 4'd15, 4'd0};
        logic [7:0] seen [$];
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step2(1'b1, sels[i], 1'b0, pat());
            else       step2(1'b0, 4'd3, 1'b0, rnd128());
            total++;
            if ({bus2.out_valid, bus2.out_sel, bus2.out_data} !== {m_valid, m_sel, m_data}) begin
                bad++;
                $display("FAIL manual got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h",
                         bus2.out_valid, bus2.out_sel, bus2.out_data, m_valid, m_sel, m_data);
            end
            if (bus2.out_valid) seen.push_back(bus2.out_data);
        end
        total++;
        if (seen.size() != 4 || seen[0] !== 8'hA5 || seen[1] !== 8'hAC || seen[2] !== 8'hAF || seen[3] !== 8'hA0) begin
            bad++;
            $display("FAIL manual_seq got %0d samples exp 4 samples A5 AC AF A0", seen.size());
        end
    endtask

    task automatic test_gapped_hold();
        int pulses = 0;
        step2(1'b1, 4'd9, 1'b0, pat());
        if (bus2.out_valid) pulses++;
        for (int i = 0; i < 4; i++) begin
            step2(1'b0, 4'($urandom_range(0, 15)), 1'b0, rnd128());
            total++;
            if ({bus2.out_valid, bus2.out_sel, bus2.out_data} !== {m_valid, m_sel, m_data}) begin
                bad++;
                $display("FAIL gapped got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h",
                         bus2.out_valid, bus2.out_sel, bus2.out_data, m_valid, m_sel, m_data);
            end
            if (bus2.out_valid) pulses++;
        end
        total++;
        if (pulses != 1 || bus2.out_data !== 8'hA9 || bus2.out_sel !== 4'd9) begin
            bad++;
            $display("FAIL gapped_hold got pulses=%0d d=%h s=%0d exp pulses=1 d=a9 s=9",
                     pulses, bus2.out_data, bus2.out_sel);
        end
    endtask

    task automatic test_scan_wrap();
        logic [3:0] seen [$];
        int errs = 0;
        for (int i = 0; i < 27; i++) begin
            bit v;
            v = !((i >= 18 && i < 21) || i >= 25);
            step2(v, 4'($urandom_range(0, 15)), 1'b1, pat());
            total++;
            if ({bus2.out_valid, bus2.out_sel, bus2.out_data} !== {m_valid, m_sel, m_data}) begin
                bad++;
                $display("FAIL scan got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h",
                         bus2.out_valid, bus2.out_sel, bus2.out_data, m_valid, m_sel, m_data);
            end
            if (bus2.out_valid) seen.push_back(bus2.out_sel);
        end
        for (int k = 0; k < seen.size(); k++) if (seen[k] !== 4'(k % 16)) errs++;
        total++;
        if (seen.size() != 22 || errs != 0) begin
            bad++;
            $display("FAIL scan_seq got %0d samples %0d out of order exp 22 samples 0..15,0..5",
                     seen.size(), errs);
        end
    endtask

    task automatic test_random();
        bit se = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) se = !se;
            step2(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), se, rnd128());
            total++;
            if ({bus2.out_valid, bus2.out_sel, bus2.out_data} !== {m_valid, m_sel, m_data}) begin
                bad++;
                $display("FAIL random[%0d] got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h", i,
                         bus2.out_valid, bus2.out_sel, bus2.out_data, m_valid, m_sel, m_data);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) step2(1'b1, 4'($urandom_range(0, 15)), 1'b0, pat());
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({bus2.out_valid, bus2.out_sel, bus2.out_data} !== 13'h0) begin
            bad++;
            $display("FAIL async_reset got v=%0b s=%0d d=%h exp 0/0/00",
                     bus2.out_valid, bus2.out_sel, bus2.out_data);
        end
        @(posedge clk); @(posedge clk); #1;
        total++;
        if ({bus2.out_valid, bus2.out_sel, bus2.out_data} !== 13'h0) begin
            bad++;
            $display("FAIL reset_active got v=%0b s=%0d d=%h exp 0/0/00",
                     bus2.out_valid, bus2.out_sel, bus2.out_data);
        end
        bus2.in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step2(1'(i >= 2), 4'($urandom_range(0, 15)), 1'b0, pat());
            total++;
            if ({bus2.out_valid, bus2.out_sel, bus2.out_data} !== {m_valid, m_sel, m_data}) begin
                bad++;
                $display("FAIL post_reset got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h",
                         bus2.out_valid, bus2.out_sel, bus2.out_data, m_valid, m_sel, m_data);
            end
        end
        bus2.in_valid = 1'b0;
    endtask

    task automatic test_sweep_l1();
        logic [31:0] data;
        logic [1:0]  s;
        logic [7:0]  last = 8'h00;
        logic [1:0]  last_s = 2'd0;
        for (int i = 0; i < 10; i++) begin
            bit v;
            v = (i != 8);
            s = (i < 4) ? 2'(i) : 2'($urandom_range(0, 3));
            data = $urandom;
            bus1.in_valid = v; bus1.sel = s; bus1.scan_en = 1'b0; bus1.in_data = data;
            @(posedge clk); #1;
            if (v) begin last = data[s*8 +: 8]; last_s = s; end
            total++;
            if ({bus1.out_valid, bus1.out_sel, bus1.out_data} !== {v, last_s, last}) begin
                bad++;
                $display("FAIL sweep_l1[%0d] got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h", i,
                         bus1.out_valid, bus1.out_sel, bus1.out_data, v, last_s, last);
            end
        end
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_sweep_l3();
        bit          ev [$];
        logic [15:0] ed [$];
        logic [5:0]  es [$];
        logic [1023:0] data;
        logic [5:0]  s;
        bool_hit: begin end
        ev = '{1'b0, 1'b0}; ed = '{16'h0, 16'h0}; es = '{6'd0, 6'd0};
        for (int i = 0; i < 11; i++) begin
            bit v, xv; logic [15:0] xd; logic [5:0] xs;
            v = (i < 8);
            s = (i == 0) ? 6'd63 : (i == 1) ? 6'd0 : 6'($urandom_range(0, 63));
            for (int w = 0; w < 32; w++) data[w*32 +: 32] = $urandom;
            bus3.in_valid = v; bus3.sel = s; bus3.scan_en = 1'b0; bus3.in_data = data;
            ev.push_back(v); ed.push_back(data[s*16 +: 16]); es.push_back(s);
            @(posedge clk); #1;
            xv = ev.pop_front(); xd = ed.pop_front(); xs = es.pop_front();
            total++;
            if (bus3.out_valid !== xv || (xv && {bus3.out_sel, bus3.out_data} !== {xs, xd})) begin
                bad++;
                $display("FAIL sweep_l3[%0d] got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h", i,
                         bus3.out_valid, bus3.out_sel, bus3.out_data, xv, xs, xd);
            end
        end
        bus3.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_gapped_hold();
        test_scan_wrap();
        test_random();
        test_mid_reset();
        test_sweep_l1();
        test_sweep_l3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer built as a tree of registered 4:1 stages; NUM_IN = 4**LEVELS channels, each DATA_W bits wide.
- Successor to the flat combinational 16:1-from-4:1 tree: adds arbitrary data width, configurable depth, one register per tree level, a valid pipeline, and an auto-scan mode that steps through channels.
- Sits between a bank of parallel sources and a single serial consumer, e.g. a display or UART feeder.

Parameters:
- DATA_W, 8, width of each input channel and of out_data.
- LEVELS, 2, number of 4:1 tree levels; NUM_IN = 4**LEVELS (default 16); legal range 1..4.
- SEL_W, 2*LEVELS, derived (localparam); channel index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*DATA_W  packed channels; channel i at [i*DATA_W +: DATA_W].
- in_valid  in  1  qualifies in_data/sel this cycle.
- sel  in  SEL_W  channel index, used when scan_en=0.
- scan_en  in  1  1 = internal scan counter chooses the channel.
- out_data  out  DATA_W  selected channel, registered.
- out_valid  out  1  out_data/out_sel valid this cycle.
- out_sel  out  SEL_W  channel index that produced out_data.

Behaviour:
- One clock; reset is asynchronous and active-low; clk and rst_n as named above.
- Reset: all stage registers, out_data, out_sel, out_valid and scan_idx go to 0 immediately. Any in-flight samples are discarded; no spurious out_valid after release.
- Effective select: eff_sel = scan_en ? scan_idx : sel, sampled with in_valid.
- Level 1 (input side): NUM_IN/4 muxes use eff_sel[1:0] on live in_data and register the results.
- Level k uses eff_sel[2k-1:2k-2], delayed k-1 cycles alongside the data.
- Level LEVELS produces out_data.
- Latency is exactly LEVELS cycles: a sample with in_valid=1 at edge n appears with out_valid=1 at edge n+LEVELS.
- Throughput: one sample per cycle; no back-pressure.
- Valid pipeline: a 1-bit valid per level. A stage's data/sel registers load only when its incoming valid=1; otherwise they hold.
- out_data and out_sel therefore hold the last valid result while out_valid=0.
- out_sel: the full eff_sel, delayed LEVELS cycles.
- scan_idx, a SEL_W-bit counter:
  - scan_en=0: forced to 0.
  - scan_en=1 and in_valid=1: increments after use; wraps NUM_IN-1 -> 0.
  - scan_en=1 and in_valid=0: holds.
- Mode change mid-stream: samples already in the pipe complete with their original select. The first sample after scan_en rises uses channel 0.
- sel is ignored when scan_en=1. in_data must be stable only at the sampling edge; later levels do not re-read in_data.
- No combinational path from any input to any output.

Decomposition:
- Package mux_tree_pkg:
  - MAX_LEVELS=4.
  - Function num_in(levels) returning 4**levels.
  - Function sel_w(levels) returning 2*levels.
- Sub-module mux4_stage (DATA_W): 4:1 mux plus output register with valid-qualified load and asynchronous reset.
- Top instantiates mux4_stage via nested generate loops: level k has 4**(LEVELS-k) instances.
- Top also holds the scan counter and the per-level select/valid delay registers.

Test Plan (DATA_W=8, LEVELS=2, channel i = 8'hA0+i):
- Reset then idle: rst_n low 3 cycles, then high, in_valid=0 for 5 cycles -> out_valid=0, out_data=8'h00, out_sel=0 throughout.
- Manual select, back-to-back: sel=5,12,15,0 on consecutive cycles with in_valid=1 -> 2 cycles later out_data=A5,AC,AF,A0 with out_sel=5,12,15,0 and out_valid=1 for 4 consecutive cycles.
- Gapped valid/hold: one sample sel=9, then in_valid=0 while in_data changes -> out_data=A9 for exactly one out_valid pulse and held afterwards; out_valid=0 after.
- Scan mode wrap: scan_en=1, in_valid=1 for 18 cycles -> out_sel sequence 0..15,0,1 and out_data A0..AF,A0,A1. With in_valid low for 3 cycles mid-stream, the sequence resumes at the next index.
- Mid-operation reset: in_valid=1 continuously, assert rst_n low asynchronously between edges -> outputs 0 immediately; after release, first out_valid only LEVELS cycles after the first new in_valid.
- Parameter sweep: repeat the manual-select test for LEVELS=1 (latency 1, channels 0..3) and LEVELS=3, DATA_W=16 (latency 3, channel 63 selected correctly).
